// File: rtl/rvv_pkg.sv
// Shared definitions for the vector register file write path: widths,
// LMUL encoding and the write-arbiter state type.
package rvv_pkg;

    localparam int VLEN_DEFAULT = 128;

    // LMUL is carried as log2 of the register group size.
    localparam logic [1:0] LMUL_M1 = 2'd0;
    localparam logic [1:0] LMUL_M2 = 2'd1;
    localparam logic [1:0] LMUL_M4 = 2'd2;
    localparam logic [1:0] LMUL_M8 = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    function automatic int vlenb_of(input int vlen);
        return vlen / 8;
    endfunction

    function automatic int nbw_of(input int vlen);
        return $clog2(8 * vlenb_of(vlen) + 1);
    endfunction

endpackage

// File: rtl/rvv_vregs_wr_arb_if.sv
// Requester handshake and register-file write port of the vector register
// write arbiter; requesters drive through master, the arbiter sits on slave.
interface rvv_vregs_wr_arb_if
    import rvv_pkg::*;
#(
    parameter int VLEN = VLEN_DEFAULT
);
    localparam int VLENB = vlenb_of(VLEN);
    localparam int NBW   = nbw_of(VLEN);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [9:0]        req_vd;
    logic [3:0]        req_lmul;
    logic [2*NBW-1:0]  req_nbytes;
    logic [1:0]        beat_valid;
    logic [1:0]        beat_ready;
    logic [2*VLEN-1:0] beat_data;
    logic [4:0]        vr_waddr;
    logic [VLENB-1:0]  vr_wstrb;
    logic [VLEN-1:0]   vr_wdata;

    modport master (
        output req_valid, req_vd, req_lmul, req_nbytes, beat_valid, beat_data,
        input  req_ready, beat_ready, vr_waddr, vr_wstrb, vr_wdata
    );

    modport slave (
        input  req_valid, req_vd, req_lmul, req_nbytes, beat_valid, beat_data,
        output req_ready, beat_ready, vr_waddr, vr_wstrb, vr_wdata
    );

endinterface

// File: rtl/rvv_byte_mask.sv
// Thermometer byte strobe: the low min(count, VLENB) bits of mask are set.
module rvv_byte_mask #(
    parameter int VLENB = 16,
    parameter int CW    = 8
) (
    input  logic [CW-1:0]    count,
    output logic [VLENB-1:0] mask
);

    always_comb begin
        // NOTE: a default before the loop keeps every bit assigned on every path, so no latch is inferred.
        mask = '0;
        for (int i = 0; i < VLENB; i++) begin
            mask[i] = (count > CW'(i));
        end
    end

endmodule

// File: rtl/rvv_vregs_wr_arb.sv
// Two-requester write arbiter for the vector register file: grants one LMUL
// register group at a time and turns its beats into strobed register writes.
module rvv_vregs_wr_arb
    import rvv_pkg::*;
#(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    rvv_vregs_wr_arb_if.slave bus,
    output logic              busy,
    output logic [1:0]        done,
    output logic [1:0]        err
);

    localparam int VLENB = vlenb_of(VLEN);
    localparam int NBW   = nbw_of(VLEN);

    arb_state_t     state;
    logic           rr_ptr;
    logic           gnt_q;
    logic [4:0]     vd_q;
    logic [2:0]     idx_q;
    logic [2:0]     last_idx_q;
    logic [NBW-1:0] rem_q;

    logic           any_req;
    logic           gsel;
    logic           hdr_fire;
    logic [4:0]     hdr_vd;
    logic [1:0]     hdr_lmul;
    logic [NBW-1:0] hdr_nbytes;
    logic [3:0]     hdr_beats;
    logic [NBW-1:0] hdr_cap;
    logic [NBW-1:0] hdr_rem;
    logic           hdr_misaligned;
    logic           beat_fire;
    logic [NBW-1:0] take;
    logic [VLENB-1:0] beat_strb;
    logic [VLEN-1:0]  beat_payload;

    // Header selection: the round-robin pointer wins ties, otherwise whoever is valid.
    always_comb begin
        any_req    = |bus.req_valid;
        gsel       = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        hdr_fire   = (state == ST_IDLE) && any_req;
        hdr_vd     = gsel ? bus.req_vd[9:5]   : bus.req_vd[4:0];
        hdr_lmul   = gsel ? bus.req_lmul[3:2] : bus.req_lmul[1:0];
        hdr_nbytes = gsel ? bus.req_nbytes[2*NBW-1:NBW] : bus.req_nbytes[NBW-1:0];

        unique case (hdr_lmul)
            LMUL_M1: hdr_beats = 4'd1;
            LMUL_M2: hdr_beats = 4'd2;
            LMUL_M4: hdr_beats = 4'd4;
            LMUL_M8: hdr_beats = 4'd8;
        endcase

        hdr_cap        = NBW'(VLENB) << hdr_lmul;
        hdr_rem        = (hdr_nbytes > hdr_cap) ? hdr_cap : hdr_nbytes;
        hdr_misaligned = (hdr_vd[3:0] & (hdr_beats - 4'd1)) != 4'd0;

        bus.req_ready = 2'b00;
        if (hdr_fire && !reset) begin
            bus.req_ready[gsel] = 1'b1;
        end

        bus.beat_ready = 2'b00;
        if (state == ST_BURST) begin
            bus.beat_ready[gnt_q] = 1'b1;
        end

        beat_fire    = (state == ST_BURST) && bus.beat_valid[gnt_q];
        beat_payload = gnt_q ? bus.beat_data[2*VLEN-1:VLEN] : bus.beat_data[VLEN-1:0];
        take         = (rem_q > NBW'(VLENB)) ? NBW'(VLENB) : rem_q;
    end

    rvv_byte_mask #(
        .VLENB (VLENB),
        .CW    (NBW)
    ) u_byte_mask (
        .count (rem_q),
        .mask  (beat_strb)
    );

    assign busy = (state == ST_BURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b0;
            gnt_q        <= 1'b0;
            vd_q         <= '0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            rem_q        <= '0;
            bus.vr_waddr <= '0;
            bus.vr_wstrb <= '0;
            bus.vr_wdata <= '0;
            done         <= '0;
            err          <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
            done         <= '0;
            err          <= '0;
            bus.vr_wstrb <= '0;

            unique case (state)
                ST_IDLE: begin
                    if (hdr_fire) begin
                        gnt_q      <= gsel;
                        vd_q       <= hdr_vd;
                        last_idx_q <= 3'(hdr_beats - 4'd1);
                        rem_q      <= hdr_rem;
                        idx_q      <= '0;
                        if (hdr_misaligned) begin
                            err[gsel] <= 1'b1;
                            rr_ptr    <= ~gsel;
                        end else begin
                            state <= ST_BURST;
                        end
                    end
                end

                ST_BURST: begin
                    if (beat_fire) begin
                        // Once rem reaches zero the mask is empty: tail registers stay undisturbed.
                        bus.vr_waddr <= vd_q + 5'(idx_q);
                        bus.vr_wdata <= beat_payload;
                        bus.vr_wstrb <= beat_strb;
                        rem_q        <= rem_q - take;
                        idx_q        <= idx_q + 3'd1;
                        if (idx_q == last_idx_q) begin
                            done[gnt_q] <= 1'b1;
                            rr_ptr      <= ~gnt_q;
                            state       <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
